// File: rtl/dut_ram_if.sv
// Bus interface for dut_ram: write enable, address, write data and read data.
// The master drives the request side; the slave (the RAM) drives registered read data.
interface dut_ram_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] out;

  modport master (
    output we,
    output addr,
    output data,
    input  out
  );

  modport slave (
    input  we,
    input  addr,
    input  data,
    output out
  );
endinterface

// File: rtl/dut_ram.sv
// dut_ram: single-port synchronous RAM, 2**ADDR_W words of DATA_W bits,
// registered read port and synchronous active-high reset that clears the whole array.
// Compile-time option DUT_RAM_WRITE_FIRST_EN: when defined, a write also loads the
// write data into the output register (write-first). Otherwise the output register
// captures the pre-write contents (read-first).
module dut_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
) (
  input logic        clk,
  input logic        rst,
  dut_ram_if.slave   bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] out_d;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] rd_word;

  assign rd_word = mem_q[bus.addr];

  // Next read-data value: selects between stored word and write data on a write.
  always_comb begin
    out_d = rd_word;
`ifdef DUT_RAM_WRITE_FIRST_EN
    if (bus.we) begin
      out_d = bus.data;
    end
`endif
  end

  // Storage array: reset clears every word at once and wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (bus.we) begin
      mem_q[bus.addr] <= bus.data;
    end
  end

  // Output register: loaded on every non-reset edge, so it always reflects the last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_dut_ram.sv
// Directed self-checking bench for dut_ram. Honors DUT_RAM_WRITE_FIRST_EN for
// the read-during-write expectations.
module tb_dut_ram;

  localparam int unsigned DataW = 16;
  localparam int unsigned AddrW = 6;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [DataW-1:0] exp_mem [64];
  logic [DataW-1:0] w;
  logic [AddrW-1:0] a;

  dut_ram_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

  dut_ram #(.DATA_W(DataW), .ADDR_W(AddrW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic r, input logic we, input logic [AddrW-1:0] ad,
                      input logic [DataW-1:0] d);
    rst      = r;
    bus.we   = we;
    bus.addr = ad;
    bus.data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DataW-1:0] obs,
                       input logic [DataW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    #2;

    // Reset state
    step(1'b1, 1'b0, 6'd0, 16'h0000);
    check("reset_out", bus.out, 16'h0000);
    step(1'b1, 1'b0, 6'd0, 16'h0000);

    // Fill all 64 locations; each write edge also shows the read-during-write result
    for (int i = 0; i < 64; i++) begin
      w = 16'($urandom);
      a = 6'(i);
      exp_mem[i] = w;
      step(1'b0, 1'b1, a, w);
`ifdef DUT_RAM_WRITE_FIRST_EN
      check("fill_rdw", bus.out, w);
`else
      check("fill_rdw", bus.out, 16'h0000);
`endif
    end

    // Boundary addresses then random read-back
    step(1'b0, 1'b0, 6'd0, 16'hFFFF);
    check("read_addr0", bus.out, exp_mem[0]);
    step(1'b0, 1'b0, 6'd63, 16'hFFFF);
    check("read_addr63", bus.out, exp_mem[63]);
    for (int i = 0; i < 100; i++) begin
      a = 6'($urandom_range(0, 63));
      step(1'b0, 1'b0, a, 16'($urandom));
      check("rand_read", bus.out, exp_mem[a]);
    end

    // Reset clears the array
    step(1'b0, 1'b1, 6'd5, 16'hBEEF);
    step(1'b0, 1'b1, 6'd63, 16'h1234);
    step(1'b0, 1'b0, 6'd5, 16'h0000);
    check("pre_rst_addr5", bus.out, 16'hBEEF);
    step(1'b1, 1'b0, 6'd5, 16'h0000);
    check("rst_out", bus.out, 16'h0000);
    step(1'b0, 1'b0, 6'd5, 16'h0000);
    check("rst_clr_addr5", bus.out, 16'h0000);
    step(1'b0, 1'b0, 6'd63, 16'h0000);
    check("rst_clr_addr63", bus.out, 16'h0000);
    step(1'b0, 1'b0, 6'd20, 16'h0000);
    check("rst_clr_addr20", bus.out, 16'h0000);

    // Read-during-write to the same address
    step(1'b0, 1'b1, 6'd10, 16'hAAAA);
    step(1'b0, 1'b0, 6'd0, 16'h0000);
    step(1'b0, 1'b1, 6'd10, 16'h5555);
`ifdef DUT_RAM_WRITE_FIRST_EN
    check("rdw_same_addr", bus.out, 16'h5555);
`else
    check("rdw_same_addr", bus.out, 16'hAAAA);
`endif
    step(1'b0, 1'b0, 6'd10, 16'h0000);
    check("rdw_after", bus.out, 16'h5555);

    // Reset beats a simultaneous write
    step(1'b1, 1'b1, 6'd7, 16'hFFFF);
    check("rst_we_out", bus.out, 16'h0000);
    step(1'b0, 1'b0, 6'd7, 16'h0000);
    check("rst_beats_we", bus.out, 16'h0000);
    step(1'b0, 1'b0, 6'd10, 16'h0000);
    check("rst_clr_addr10", bus.out, 16'h0000);

    // Hold a read with we=0 and junk on the data bus
    step(1'b0, 1'b1, 6'd3, 16'h00C3);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 6'd3, 16'hFFFF);
      check("hold_addr3", bus.out, 16'h00C3);
    end
    step(1'b0, 1'b0, 6'd4, 16'hFFFF);
    check("hold_addr4", bus.out, 16'h0000);
    step(1'b0, 1'b0, 6'd3, 16'h0000);
    check("hold_reread3", bus.out, 16'h00C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
